// File: rtl/multi_zone_thermostat.sv
// multi_zone_thermostat: NZ independent heat/cool controllers with a
// shared hysteresis half-band and a per-zone minimum-dwell counter.
//
// Ports:
//   clk     system clock, rising edge
//   reset   synchronous active-high reset
//   start   level enable; low forces every zone to IDLE
//   troom   packed room temperatures, zone z at [z*TW +: TW]
//   tref    packed reference temperatures, same packing
//   dt      hysteresis half-band shared by all zones
//   h       heater enable per zone (zone in HEAT)
//   c       cooler enable per zone (zone in COOL)
//   active  registered OR of all h and c bits
module multi_zone_thermostat #(
    parameter int TW        = 7,
    parameter int NZ        = 4,
    parameter int MIN_DWELL = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [NZ*TW-1:0] troom,
    input  logic [NZ*TW-1:0] tref,
    input  logic [TW-1:0]    dt,
    output logic [NZ-1:0]    h,
    output logic [NZ-1:0]    c,
    output logic             active
);

    localparam int CW = $clog2(MIN_DWELL + 1);
    localparam logic [CW-1:0] FULL = CW'(MIN_DWELL);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HEAT = 2'd1,
        COOL = 2'd2
    } state_t;

    for (genvar z = 0; z < NZ; z++) begin : g_zone
        logic [TW:0]   tr;
        logic [TW:0]   tf;
        logic [TW:0]   d;
        logic          lo;
        logic          hi;
        logic          at_h;
        logic          at_c;
        logic          ok;
        state_t        state;
        state_t        nxt;
        logic [CW-1:0] cnt;
        logic          h_q;
        logic          c_q;

        // One extra bit so troom+dt and tref+dt never wrap.
        assign tr = {1'b0, troom[z*TW +: TW]};
        assign tf = {1'b0, tref[z*TW +: TW]};
        assign d  = {1'b0, dt};

        assign lo   = (tr + d) < tf;
        assign hi   = tr > (tf + d);
        assign at_h = tr >= tf;
        assign at_c = tr <= tf;
        assign ok   = cnt == FULL;

        // HEAT and COOL only ever exit to IDLE.
        always_comb begin
            nxt = state;
            unique case (state)
                IDLE: begin
                    if (ok && lo)
                        nxt = HEAT;
                    else if (ok && hi)
                        nxt = COOL;
                end
                HEAT: if (ok && at_h) nxt = IDLE;
                COOL: if (ok && at_c) nxt = IDLE;
                default: nxt = IDLE;
            endcase
        end

        // Counter presets to FULL on reset/stop so the first
        // demand afterwards is served without a dwell.
        always_ff @(posedge clk) begin
            if (reset || !start) begin
                state <= IDLE;
                cnt   <= FULL;
                h_q   <= 1'b0;
                c_q   <= 1'b0;
            end else begin
                state <= nxt;
                if (nxt != state)
                    cnt <= '0;
                else if (cnt != FULL)
                    cnt <= cnt + CW'(1);
                h_q <= (nxt == HEAT);
                c_q <= (nxt == COOL);
            end
        end

        assign h[z] = h_q;
        assign c[z] = c_q;
    end

    // Lags h/c by one edge.
    always_ff @(posedge clk) begin
        if (reset)
            active <= 1'b0;
        else
            active <= |(h | c);
    end

endmodule

// File: tb/tb_multi_zone_thermostat.sv
// tb_multi_zone_thermostat: directed and randomized checks of
// multi_zone_thermostat (NZ=2, TW=7, MIN_DWELL=4) against a model.
module tb_multi_zone_thermostat;

    localparam int TW = 7;
    localparam int NZ = 2;
    localparam int MD = 4;

    logic             clk;
    logic             reset;
    logic             start;
    logic [NZ*TW-1:0] troom;
    logic [NZ*TW-1:0] tref;
    logic [TW-1:0]    dt;
    logic [NZ-1:0]    h;
    logic [NZ-1:0]    c;
    logic             active;

    int checks   = 0;
    int failures = 0;

    // Model: mode 0=idle 1=heat 2=cool, age = edges since last change.
    int mode [NZ];
    int age  [NZ];
    bit act_m;

    multi_zone_thermostat #(
        .TW(TW),
        .NZ(NZ),
        .MIN_DWELL(MD)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .troom(troom),
        .tref(tref),
        .dt(dt),
        .h(h),
        .c(c),
        .active(active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_zone(input int z, input int tr, input int tf);
        troom[z*TW +: TW] = TW'(tr);
        tref[z*TW +: TW]  = TW'(tf);
    endtask

    task automatic model_edge();
        int  tr, tf, d, n;
        bit  any;
        any = 1'b0;
        for (int z = 0; z < NZ; z++)
            if (mode[z] != 0) any = 1'b1;
        if (reset) begin
            act_m = 1'b0;
            for (int z = 0; z < NZ; z++) begin
                mode[z] = 0;
                age[z]  = 1000;
            end
        end else begin
            act_m = any;
            for (int z = 0; z < NZ; z++) begin
                if (!start) begin
                    mode[z] = 0;
                    age[z]  = 1000;
                end else begin
                    tr = int'(troom[z*TW +: TW]);
                    tf = int'(tref[z*TW +: TW]);
                    d  = int'(dt);
                    n  = mode[z];
                    if (age[z] >= MD) begin
                        if (mode[z] == 0 && tr + d < tf) n = 1;
                        else if (mode[z] == 0 && tr > tf + d) n = 2;
                        else if (mode[z] == 1 && tr >= tf) n = 0;
                        else if (mode[z] == 2 && tr <= tf) n = 0;
                    end
                    if (n != mode[z]) begin
                        mode[z] = n;
                        age[z]  = 0;
                    end else if (age[z] < 1000) begin
                        age[z]++;
                    end
                end
            end
        end
    endtask

    // One clock edge, model update, then sample 1 time unit later.
    task automatic step();
        logic [NZ-1:0] eh, ec;
        @(posedge clk);
        model_edge();
        #1;
        for (int z = 0; z < NZ; z++) begin
            eh[z] = (mode[z] == 1);
            ec[z] = (mode[z] == 2);
        end
        chk("model_h", 32'(h), 32'(eh));
        chk("model_c", 32'(c), 32'(ec));
        chk("model_active", 32'(active), 32'(act_m));
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b1;
        troom = '0;
        tref  = '0;
        dt    = 7'd2;
        set_zone(0, 10, 30);
        set_zone(1, 19, 20);
        for (int z = 0; z < NZ; z++) begin
            mode[z] = 0;
            age[z]  = 1000;
        end
        act_m = 1'b0;
        @(negedge clk);

        // Reset held two cycles.
        for (int i = 0; i < 2; i++) begin
            step();
            chk("rst_h", 32'(h), 0);
            chk("rst_c", 32'(c), 0);
            chk("rst_active", 32'(active), 0);
        end
        reset = 1'b0;
        step();
        chk("rel_h0", 32'(h[0]), 1);
        chk("rel_active_lag", 32'(active), 0);
        step();
        chk("rel_active", 32'(active), 1);

        // Dwell hold and hysteresis.
        start = 1'b0;
        step();
        chk("stop_h", 32'(h), 0);
        start = 1'b1;
        set_zone(0, 15, 20);
        step();
        chk("heat_on", 32'(h[0]), 1);
        set_zone(0, 25, 20);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("heat_hold", 32'(h[0]), 1);
            chk("zone1_h", 32'(h[1]), 0);
        end
        step();
        chk("heat_off", 32'(h[0]), 0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("idle_dwell_c", 32'(c[0]), 0);
            chk("zone1_c", 32'(c[1]), 0);
        end
        step();
        chk("cool_on", 32'(c[0]), 1);

        // Dead band in zone 1 while zone 0 moves freely.
        for (int i = 0; i < 20; i++) begin
            set_zone(0, $urandom_range(0, 127), $urandom_range(0, 127));
            step();
            chk("deadband_h1", 32'(h[1]), 0);
            chk("deadband_c1", 32'(c[1]), 0);
        end

        // Width boundaries.
        start = 1'b0;
        step();
        start = 1'b1;
        dt = 7'd5;
        set_zone(0, 0, 2);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("nowrap_lo", 32'({h[0], c[0]}), 0);
        end
        set_zone(0, 127, 125);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("nowrap_hi", 32'({h[0], c[0]}), 0);
        end
        dt = 7'd127;
        set_zone(0, 0, 127);
        step();
        chk("nowrap_dtmax", 32'({h[0], c[0]}), 0);
        dt = 7'd5;
        set_zone(0, 127, 120);
        step();
        chk("hot_edge", 32'(c[0]), 1);

        // start dropped with the cool counter at 1.
        step();
        start = 1'b0;
        step();
        chk("stop_cool", 32'(c[0]), 0);
        start = 1'b1;
        step();
        chk("restart_cool", 32'(c[0]), 1);

        // Simultaneous events in both zones.
        start = 1'b0;
        step();
        start = 1'b1;
        dt = 7'd2;
        set_zone(0, 10, 30);
        set_zone(1, 50, 20);
        step();
        chk("simul_h", 32'(h), 32'b01);
        chk("simul_c", 32'(c), 32'b10);
        step();
        chk("simul_active", 32'(active), 1);

        // Randomized run against the model.
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 99) == 0);
            start = ($urandom_range(0, 29) != 0);
            if ($urandom_range(0, 3) == 0)
                dt = TW'($urandom_range(0, 6));
            for (int z = 0; z < NZ; z++) begin
                int b;
                if ($urandom_range(0, 2) == 0) begin
                    b = $urandom_range(10, 117);
                    set_zone(z, b + $urandom_range(0, 20) - 10, b);
                end
            end
            step();
        end
        reset = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
